// File: rtl/cpu_isa_pkg.sv
// cpu_isa_pkg: opcodes, control-vector layout and instruction field offsets for the 16-bit CPU
package cpu_isa_pkg;

    localparam logic [3:0] OP_LDA_IMM    = 4'h0;
    localparam logic [3:0] OP_STA_IMM    = 4'h1;
    localparam logic [3:0] OP_CAL_ADD    = 4'h2;
    localparam logic [3:0] OP_CAL_SUB    = 4'h3;
    localparam logic [3:0] OP_CAL_MUL    = 4'h4;
    localparam logic [3:0] OP_CAL_SLT    = 4'h5;
    localparam logic [3:0] OP_IMM_ADD    = 4'h6;
    localparam logic [3:0] OP_IMM_SUB    = 4'h7;
    localparam logic [3:0] OP_IMM_MUL    = 4'h8;
    localparam logic [3:0] OP_BAF_IMMSUB = 4'h9;
    localparam logic [3:0] OP_BAF_REGSUB = 4'hA;
    localparam logic [3:0] OP_NONE       = 4'hF;

    // Control vector is {alufunc, branch, flush, regwrite, memwrite, memtoreg, immediate, forward}
    localparam int CB_FORWARD   = 0;
    localparam int CB_IMMEDIATE = 1;
    localparam int CB_MEMTOREG  = 2;
    localparam int CB_MEMWRITE  = 3;
    localparam int CB_REGWRITE  = 4;
    localparam int CB_FLUSH     = 5;
    localparam int CB_BRANCH    = 6;
    localparam int CB_ALUFUNC   = 7;
    localparam int CTRL_LOW_W   = 7;

    function automatic int ctrl_w(input int alufunc_w);
        return alufunc_w + CTRL_LOW_W;
    endfunction

    // Instruction is {opcode, rd, rs, rt/imm} from the MSB down
    function automatic int rt_lsb(input int reg_addr_w);
        return 0 * reg_addr_w;
    endfunction

    function automatic int rs_lsb(input int reg_addr_w);
        return reg_addr_w;
    endfunction

    function automatic int rd_lsb(input int reg_addr_w);
        return 2 * reg_addr_w;
    endfunction

    function automatic int op_lsb(input int reg_addr_w);
        return 3 * reg_addr_w;
    endfunction

endpackage

// File: rtl/opcode_ctrl_rom.sv
// opcode_ctrl_rom: combinational opcode to control vector, illegal flag and source-register usage
module opcode_ctrl_rom
    import cpu_isa_pkg::*;
#(
    parameter int OPCODE_W  = 4,
    parameter int ALUFUNC_W = 2
) (
    input  logic [OPCODE_W-1:0]             opcode,
    output logic [ALUFUNC_W+CTRL_LOW_W-1:0] ctrl,
    output logic                            illegal,
    output logic                            rs_used,
    output logic                            rt_used
);

    logic [3:0]            op;
    logic [1:0]            af;
    logic [CTRL_LOW_W-1:0] low;

    // Decode the low four opcode bits; any set bit above them makes the opcode illegal
    always_comb begin
        op      = opcode[3:0];
        af      = '0;
        low     = '0;
        illegal = (opcode >> 4) != '0;
        case (op)
            OP_LDA_IMM:    low = 7'b0010111;
            OP_STA_IMM:    low = 7'b0001010;
            OP_CAL_ADD, OP_CAL_SUB, OP_CAL_MUL, OP_CAL_SLT: begin
                af  = 2'(op - OP_CAL_ADD);
                low = 7'b0010001;
            end
            OP_IMM_ADD, OP_IMM_SUB, OP_IMM_MUL: begin
                af  = 2'(op - OP_IMM_ADD);
                low = 7'b0010011;
            end
            OP_BAF_IMMSUB: begin
                af  = 2'b01;
                low = 7'b1100010;
            end
            OP_BAF_REGSUB: begin
                af  = 2'b01;
                low = 7'b1100000;
            end
            OP_NONE:       low = '0;
            default:       illegal = 1'b1;
        endcase
        if (illegal) begin
            af  = '0;
            low = '0;
        end
        ctrl    = {ALUFUNC_W'(af), low};
        rs_used = !(opcode == OPCODE_W'(OP_LDA_IMM) || opcode == OPCODE_W'(OP_NONE));
        rt_used = !illegal && (op inside {OP_CAL_ADD, OP_CAL_SUB, OP_CAL_MUL, OP_CAL_SLT, OP_BAF_REGSUB});
    end

endmodule

// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage: instruction decode with valid/ready ID/EX register, load-use bubble, flush and illegal counting
module decode_ctrl_stage
    import cpu_isa_pkg::*;
#(
    parameter int OPCODE_W   = 4,
    parameter int REG_ADDR_W = 4,
    parameter int INSTR_W    = OPCODE_W + 3 * REG_ADDR_W,
    parameter int ALUFUNC_W  = 2,
    parameter int ILL_CNT_W  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [INSTR_W-1:0]    i_instr,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_ready,
    input  logic                  i_flush,
    output logic                  o_valid,
    output logic [ALUFUNC_W-1:0]  o_alufunc,
    output logic                  o_branch,
    output logic                  o_flush,
    output logic                  o_regwrite,
    output logic                  o_memwrite,
    output logic                  o_memtoreg,
    output logic                  o_immediate,
    output logic                  o_forward,
    output logic [REG_ADDR_W-1:0] o_rd,
    output logic [REG_ADDR_W-1:0] o_rs,
    output logic [REG_ADDR_W-1:0] o_rt,
    output logic                  o_illegal,
    output logic [ILL_CNT_W-1:0]  o_illegal_cnt
);

    localparam int CTRL_W = ctrl_w(ALUFUNC_W);
    localparam int OP_LSB = op_lsb(REG_ADDR_W);
    localparam int RD_LSB = rd_lsb(REG_ADDR_W);
    localparam int RS_LSB = rs_lsb(REG_ADDR_W);
    localparam int RT_LSB = rt_lsb(REG_ADDR_W);

    logic [OPCODE_W-1:0]   opcode;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [CTRL_W-1:0]     dec_ctrl;
    logic                  dec_illegal;
    logic                  rs_used;
    logic                  rt_used;
    logic [CTRL_W-1:0]     ctrl_q;
    logic                  hazard;
    logic                  accept;

    assign opcode = i_instr[OP_LSB +: OPCODE_W];
    assign rd     = i_instr[RD_LSB +: REG_ADDR_W];
    assign rs     = i_instr[RS_LSB +: REG_ADDR_W];
    assign rt     = i_instr[RT_LSB +: REG_ADDR_W];

    opcode_ctrl_rom #(
        .OPCODE_W (OPCODE_W),
        .ALUFUNC_W(ALUFUNC_W)
    ) u_rom (
        .opcode (opcode),
        .ctrl   (dec_ctrl),
        .illegal(dec_illegal),
        .rs_used(rs_used),
        .rt_used(rt_used)
    );

    // A held load whose destination feeds the incoming instruction must leave before that instruction enters
    assign hazard  = o_valid & o_memtoreg & i_valid & ((rs_used & (rs == o_rd)) | (rt_used & (rt == o_rd)));
    assign o_ready = !i_flush & !hazard & (!o_valid | i_ready);
    assign accept  = i_valid & o_ready;

    assign o_alufunc   = ctrl_q[CB_ALUFUNC +: ALUFUNC_W];
    assign o_branch    = ctrl_q[CB_BRANCH];
    assign o_flush     = ctrl_q[CB_FLUSH];
    assign o_regwrite  = ctrl_q[CB_REGWRITE];
    assign o_memwrite  = ctrl_q[CB_MEMWRITE];
    assign o_memtoreg  = ctrl_q[CB_MEMTOREG];
    assign o_immediate = ctrl_q[CB_IMMEDIATE];
    assign o_forward   = ctrl_q[CB_FORWARD];

    // ID/EX register: load on accept, otherwise empty to a zero-control bubble on flush or downstream take
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid   <= 1'b0;
            ctrl_q    <= '0;
            o_illegal <= 1'b0;
            o_rd      <= '0;
            o_rs      <= '0;
            o_rt      <= '0;
        end else if (accept) begin
            o_valid   <= 1'b1;
            ctrl_q    <= dec_ctrl;
            o_illegal <= dec_illegal;
            o_rd      <= rd;
            o_rs      <= rs;
            o_rt      <= rt;
        end else if (i_flush | i_ready) begin
            o_valid   <= 1'b0;
            ctrl_q    <= '0;
            o_illegal <= 1'b0;
        end
    end

    // Saturating count of illegal opcodes that actually enter the stage
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            o_illegal_cnt <= '0;
        else if (accept && dec_illegal && !(&o_illegal_cnt))
            o_illegal_cnt <= o_illegal_cnt + 1'b1;
    end

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// tb_decode_ctrl_stage: directed and random checks of the decode stage against a spec-level reference model
module tb_decode_ctrl_stage;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [15:0] i_instr;
    logic        i_valid;
    logic        o_ready;
    logic        i_ready;
    logic        i_flush;
    logic        o_valid;
    logic [1:0]  o_alufunc;
    logic        o_branch, o_flush, o_regwrite, o_memwrite, o_memtoreg, o_immediate, o_forward;
    logic [3:0]  o_rd, o_rs, o_rt;
    logic        o_illegal;
    logic [7:0]  o_illegal_cnt;
    logic [8:0]  got_ctrl;

    int n_tests = 0;
    int n_fail  = 0;

    bit         m_valid;
    bit         m_bubble;
    logic [8:0] m_ctrl;
    bit         m_ill;
    logic [3:0] m_rd, m_rs, m_rt;
    int         m_cnt;

    decode_ctrl_stage #(.ILL_CNT_W(8)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_instr(i_instr), .i_valid(i_valid), .o_ready(o_ready),
        .i_ready(i_ready), .i_flush(i_flush), .o_valid(o_valid), .o_alufunc(o_alufunc),
        .o_branch(o_branch), .o_flush(o_flush), .o_regwrite(o_regwrite), .o_memwrite(o_memwrite),
        .o_memtoreg(o_memtoreg), .o_immediate(o_immediate), .o_forward(o_forward),
        .o_rd(o_rd), .o_rs(o_rs), .o_rt(o_rt), .o_illegal(o_illegal), .o_illegal_cnt(o_illegal_cnt)
    );

    always #5 i_clk = ~i_clk;

    assign got_ctrl = {o_alufunc, o_branch, o_flush, o_regwrite, o_memwrite, o_memtoreg, o_immediate, o_forward};

    // {illegal, alufunc, branch, flush, regwrite, memwrite, memtoreg, immediate, forward} straight from the opcode table
    function automatic logic [9:0] ref_dec(input logic [3:0] op);
        case (op)
            4'd0:    return {1'b0, 9'b00_0010111};
            4'd1:    return {1'b0, 9'b00_0001010};
            4'd2:    return {1'b0, 9'b00_0010001};
            4'd3:    return {1'b0, 9'b01_0010001};
            4'd4:    return {1'b0, 9'b10_0010001};
            4'd5:    return {1'b0, 9'b11_0010001};
            4'd6:    return {1'b0, 9'b00_0010011};
            4'd7:    return {1'b0, 9'b01_0010011};
            4'd8:    return {1'b0, 9'b10_0010011};
            4'd9:    return {1'b0, 9'b01_1100010};
            4'd10:   return {1'b0, 9'b01_1100000};
            4'd15:   return {1'b0, 9'b00_0000000};
            default: return {1'b1, 9'b00_0000000};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_valid  = 0;
        m_bubble = 0;
        m_ctrl   = '0;
        m_ill    = 0;
        m_cnt    = 0;
    endtask

    // One clock: drive, check o_ready mid-cycle, then advance the model and check registered outputs after the edge
    task automatic cycle(input bit v, input logic [15:0] ins, input bit rdy, input bit fl);
        logic [9:0] d;
        logic [3:0] op;
        bit         rs_u, rt_u, haz, rdy_exp;
        i_valid = v;
        i_instr = ins;
        i_ready = rdy;
        i_flush = fl;
        #2;
        op      = ins[15:12];
        d       = ref_dec(op);
        rs_u    = (op != 4'd0) && (op != 4'd15);
        rt_u    = (op inside {4'd2, 4'd3, 4'd4, 4'd5, 4'd10});
        haz     = m_valid && m_ctrl[2] && v && ((rs_u && ins[7:4] == m_rd) || (rt_u && ins[3:0] == m_rd));
        rdy_exp = !fl && !haz && (!m_valid || rdy);
        chk("ready", {31'd0, o_ready}, {31'd0, rdy_exp});
        @(posedge i_clk);
        #1;
        if (fl) begin
            m_valid  = 0;
            m_bubble = 0;
        end else if (haz) begin
            if (rdy) begin
                m_valid  = 0;
                m_bubble = 1;
            end
        end else if (v && rdy_exp) begin
            m_valid  = 1;
            m_bubble = 0;
            m_ctrl   = d[8:0];
            m_ill    = d[9];
            m_rd     = ins[11:8];
            m_rs     = ins[7:4];
            m_rt     = ins[3:0];
            if (m_ill && m_cnt < 255) m_cnt++;
        end else if (m_valid && rdy) begin
            m_valid  = 0;
            m_bubble = 0;
        end
        chk("valid", {31'd0, o_valid}, {31'd0, m_valid});
        chk("ill_cnt", {24'd0, o_illegal_cnt}, m_cnt);
        if (m_valid) begin
            chk("ctrl", {23'd0, got_ctrl}, {23'd0, m_ctrl});
            chk("illegal", {31'd0, o_illegal}, {31'd0, m_ill});
            chk("fields", {20'd0, o_rd, o_rs, o_rt}, {20'd0, m_rd, m_rs, m_rt});
        end
        if (m_bubble) chk("bubble_ctrl", {23'd0, got_ctrl}, 32'd0);
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_instr = '0;
        i_ready = 1'b0;
        i_flush = 1'b0;
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_ctrl", {23'd0, got_ctrl}, 32'd0);
        chk("rst_cnt", {24'd0, o_illegal_cnt}, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        chk("rst_ready", {31'd0, o_ready}, 32'd1);

        cycle(1, 16'h2123, 1, 0);
        chk("cal_alufunc", {30'd0, o_alufunc}, 32'd0);
        chk("cal_regwrite", {31'd0, o_regwrite}, 32'd1);
        chk("cal_forward", {31'd0, o_forward}, 32'd1);
        chk("cal_fields", {20'd0, o_rd, o_rs, o_rt}, 32'h123);

        cycle(1, 16'h0507, 1, 0);
        cycle(1, 16'h2350, 1, 0);
        chk("lu_bubble", {31'd0, o_valid}, 32'd0);
        cycle(1, 16'h2350, 1, 0);
        chk("lu_after", {20'd0, o_rd, o_rs, o_rt}, 32'h350);

        cycle(1, 16'h6123, 1, 0);
        repeat (3) cycle(1, 16'h2456, 0, 0);
        chk("stall_held", {20'd0, o_rd, o_rs, o_rt}, 32'h123);
        cycle(1, 16'h2456, 1, 0);
        chk("stall_next", {20'd0, o_rd, o_rs, o_rt}, 32'h456);

        cycle(1, 16'hA123, 1, 0);
        cycle(1, 16'hC777, 0, 1);
        chk("flush_valid", {31'd0, o_valid}, 32'd0);
        cycle(1, 16'hC777, 1, 0);
        chk("flush_kept", {20'd0, o_rd, o_rs, o_rt}, 32'h777);

        for (int k = 0; k < 400; k++) begin
            logic [15:0] ins;
            ins = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
            if ($urandom_range(0, 3) == 0) ins[15:12] = 4'd0;
            cycle($urandom_range(0, 9) < 8, ins, $urandom_range(0, 9) < 7, $urandom_range(0, 11) == 0);
        end

        cycle(0, 16'h0000, 1, 0);
        cycle(1, 16'h6123, 0, 0);
        chk("pre_rst_valid", {31'd0, o_valid}, 32'd1);
        i_valid = 1'b0;
        i_rst_n = 1'b0;
        #1;
        chk("async_valid", {31'd0, o_valid}, 32'd0);
        chk("async_ctrl", {23'd0, got_ctrl}, 32'd0);
        chk("async_fields", {20'd0, o_rd, o_rs, o_rt}, 32'd0);
        chk("async_cnt", {24'd0, o_illegal_cnt}, 32'd0);
        model_reset();
        @(negedge i_clk);
        i_rst_n = 1'b1;

        for (int k = 0; k < 300; k++) cycle(1, 16'hB000, 1, 0);
        chk("sat_cnt", {24'd0, o_illegal_cnt}, 32'd255);
        chk("sat_illegal", {31'd0, o_illegal}, 32'd1);
        chk("sat_ctrl", {23'd0, got_ctrl}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_ctrl_stage.md
# decode_ctrl_stage

Parametrised decode stage for the 16-bit CPU. It splits an instruction into its opcode and register fields and decodes the control vector. The result is held in a valid/ready ID/EX pipeline register. The stage inserts a one-cycle bubble on load-use hazards, kills its contents on a branch flush, and flags and counts illegal opcodes. It sits between the fetch stage and the execute stage.

## Interface
- OPCODE_W, 4, opcode field width (≥4)
- REG_ADDR_W, 4, width of each of the rd/rs/rt fields
- INSTR_W, OPCODE_W+3*REG_ADDR_W, instruction width (16 at defaults)
- ALUFUNC_W, 2, ALU function width (≥2; upper bits zero-filled)
- ILL_CNT_W, 8, illegal-opcode counter width
- i_clk  in  1  clock; all state on rising edge
- i_rst_n  in  1  reset; asynchronous, active-low
- i_instr  in  INSTR_W  instruction, laid out as {opcode, rd, rs, rt/imm} from the MSB down
- i_valid  in  1  upstream instruction valid
- o_ready  out  1  stage accepts i_instr this cycle (combinational)
- i_ready  in  1  execute stage accepts the output register
- i_flush  in  1  branch taken in EX: kill the stage
- o_valid  out  1  output register holds a live instruction
- o_alufunc  out  ALUFUNC_W  ALU function
- o_branch, o_flush, o_regwrite, o_memwrite, o_memtoreg, o_immediate, o_forward  out  1 each  control bits
- o_rd, o_rs, o_rt  out  REG_ADDR_W each  register fields (o_rt doubles as the immediate)
- o_illegal  out  1  held instruction had an undefined opcode
- o_illegal_cnt  out  ILL_CNT_W  saturating count of accepted illegal opcodes

## Operation
- Control vector, in the order {alufunc, branch, flush, regwrite, memwrite, memtoreg, immediate, forward}:
  - 0000 LDA: 00_0010111
  - 0001 STA: 00_0001010
  - 0010/0011/0100/0101 CAL add/sub/mul/SLT: alufunc 00/01/10/11, low bits 0010001
  - 0110/0111/1000 IMM add/sub/mul: alufunc 00/01/10, low bits 0010011
  - 1001 BAF_immsub: 01_1100010
  - 1010 BAF_regsub: 01_1100000
  - 1111 NONE: all zero
- Illegal opcodes are 1011–1110 and any opcode with a nonzero bit above bit 3.
  - They decode to the all-zero vector with o_illegal=1.
  - They still advance with o_valid=1.
- Source usage (for hazard checking):
  - rs is a source for every opcode except LDA and NONE.
  - rt is also a source for CAL_* and BAF_regsub.
- Load-use hazard: `hazard = o_valid & o_memtoreg & i_valid & (rs used & rs==o_rd | rt used & rt==o_rd)`.
- Priority, evaluated each cycle:
  1. i_flush: o_ready=0; next o_valid=0; the counter does not change.
  2. hazard: o_ready=0. If i_ready=1, the register loads a bubble (o_valid=0, all control bits 0) and the LDA leaves. If i_ready=0, the register holds.
  3. Otherwise: o_ready = !o_valid | i_ready. On `i_valid & o_ready` the decoded instruction is loaded with o_valid=1.
  4. If o_valid & i_ready and no new instruction is accepted, o_valid becomes 0.
- While o_valid & !i_ready, all outputs hold stable.
- o_illegal_cnt increments on each accepted illegal opcode and saturates at all-ones (no wrap).
- Reset: every output register and the counter go to 0, so o_valid=0 and all control outputs are 0. o_ready reads 1 while reset is deasserted and no flush is active.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is presented with o_valid=1 after edge N.
- Full throughput is one instruction per cycle while i_ready=1 and there are no hazards.
- A load-use hazard costs exactly one bubble cycle. The dependent instruction is accepted on the cycle after the LDA leaves.
- o_ready is combinational from i_valid, i_instr, i_ready, i_flush and the register state. No output depends combinationally on i_ready except o_ready.
- i_flush takes effect at the next edge. A flush coincident with a hazard or stall still clears o_valid.
- Asserting i_rst_n low mid-transfer clears the stage immediately (asynchronous). Any in-flight instruction is lost.

## Structure
- Shared package cpu_isa_pkg holds:
  - the opcode localparams (LDA_imm … NONE)
  - control-vector bit indices and width (CTRL_W = ALUFUNC_W+7)
  - the instruction field offsets
- One natural sub-module: opcode_ctrl_rom. It is a pure combinational function of opcode → {control vector, illegal, rs_used, rt_used}.
- The top level holds the handshake, hazard detection, the ID/EX register and the counter.

## Test plan
- Reset, then i_valid=1 with i_instr=0x2123 (CAL_add) and i_ready=1 → next cycle o_valid=1, alufunc=00, regwrite=1, forward=1, rd=1, rs=2, rt=3.
- LDA 0x0507 followed by CAL_add 0x2350 (rs=5), i_ready=1 → exactly one bubble cycle (o_valid=0) with o_ready=0, then CAL_add is presented.
- IMM_add is held with i_ready=0 for 3 cycles → o_ready=0 and outputs stable throughout. i_ready=1 then advances the next instruction.
- i_flush=1 while a BAF_regsub is held and another instruction is waiting → o_valid=0 next cycle, the waiting instruction is not consumed, and the counter is unchanged.
- 300 back-to-back 0xB000 instructions (illegal) with ILL_CNT_W=8 → o_illegal=1 on each and o_illegal_cnt stops at 255. Control outputs stay all zero.
- i_rst_n pulsed low while o_valid=1 → all outputs are 0 immediately, before the next clock edge.
